// File: rtl/ripple_count_sampler_if.sv
// Bundle of ripple counter inputs, control strobes and sampled-count results.
// The master side drives the counter bits and controls; the slave side reports the results.
interface ripple_count_sampler_if #(
  parameter int ACC_W = 16
);
  logic             Q0;
  logic             Q1;
  logic             Q2;
  logic             Q3;
  logic             en;
  logic             clr_acc;
  logic [3:0]       count_sync;
  logic             count_valid;
  logic [3:0]       delta;
  logic             wrap_pulse;
  logic [ACC_W-1:0] total;
  logic             total_ovf;

  modport master (
    output Q0, Q1, Q2, Q3, en, clr_acc,
    input  count_sync, count_valid, delta, wrap_pulse, total, total_ovf
  );

  modport slave (
    input  Q0, Q1, Q2, Q3, en, clr_acc,
    output count_sync, count_valid, delta, wrap_pulse, total, total_ovf
  );
endinterface

// File: rtl/ripple_count_sampler.sv
// Samples a 4-bit asynchronous ripple counter into the clk domain. Only settled values
// are accepted; each accepted change reports count, delta and wrap, and accumulates a total.
module ripple_count_sampler #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int ACC_W         = 16
) (
  input logic                    clk,
  input logic                    rst,
  ripple_count_sampler_if.slave  bus
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);

  typedef enum logic {S_INIT = 1'b0, S_TRACK = 1'b1} state_t;

  function automatic logic [STAB_W-1:0] sat_inc(input logic [STAB_W-1:0] v);
    return (v == STAB_MAX) ? v : v + 1'b1;
  endfunction

  logic [3:0]        r_sync_p0 [SYNC_STAGES];
  logic [3:0]        w_s;
  logic [3:0]        r_s_prev_p1;
  logic [STAB_W-1:0] r_stab_cnt_p1;
  logic              w_stable;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_load;
  logic              w_accept;

  logic [3:0]        r_count_sync;
  logic              r_count_valid;
  logic [3:0]        r_delta;
  logic              r_wrap_pulse;
  logic [ACC_W-1:0]  r_total;
  logic              r_total_ovf;
  logic [3:0]        w_delta;
  logic [ACC_W:0]    w_sum;

  // Stage p0: per-bit synchronizer chains, no coherence between bits yet
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync_p0[i] <= '0;
    end else begin
      r_sync_p0[0] <= {bus.Q3, bus.Q2, bus.Q1, bus.Q0};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync_p0[i] <= r_sync_p0[i-1];
    end
  end

  assign w_s = r_sync_p0[SYNC_STAGES-1];

  // Stage p1: stability filter; s must also match s_prev so a saturated count from an
  // older value cannot pass a fresh transient in its first cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_prev_p1   <= '0;
      r_stab_cnt_p1 <= '0;
    end else begin
      r_s_prev_p1   <= w_s;
      r_stab_cnt_p1 <= (w_s != r_s_prev_p1) ? '0 : sat_inc(r_stab_cnt_p1);
    end
  end

  assign w_stable = (r_stab_cnt_p1 == STAB_MAX) && (w_s == r_s_prev_p1);
  assign w_delta  = w_s - r_count_sync;
  assign w_sum    = {1'b0, r_total} + {{(ACC_W-3){1'b0}}, w_delta};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    if (!bus.en) begin
      w_state_nxt = S_INIT;
    end else begin
      case (r_state)
        S_INIT: begin
          if (w_stable) begin
            w_load      = 1'b1;
            w_state_nxt = S_TRACK;
          end
        end
        S_TRACK: begin
          if (w_stable && (w_s != r_count_sync)) w_accept = 1'b1;
        end
        default: w_state_nxt = S_INIT;
      endcase
    end
  end

  // Stage p2: registered event outputs and running total
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count_sync  <= '0;
      r_count_valid <= 1'b0;
      r_delta       <= '0;
      r_wrap_pulse  <= 1'b0;
      r_total       <= '0;
      r_total_ovf   <= 1'b0;
    end else begin
      r_count_valid <= w_accept;
      r_wrap_pulse  <= w_accept && (w_s < r_count_sync);
      if (w_load || w_accept) r_count_sync <= w_s;
      if (w_accept)           r_delta      <= w_delta;
      if (bus.clr_acc) begin
        r_total     <= '0;
        r_total_ovf <= 1'b0;
      end else if (w_accept) begin
        r_total     <= w_sum[ACC_W-1:0];
        r_total_ovf <= r_total_ovf | w_sum[ACC_W];
      end
    end
  end

  assign bus.count_sync  = r_count_sync;
  assign bus.count_valid = r_count_valid;
  assign bus.delta       = r_delta;
  assign bus.wrap_pulse  = r_wrap_pulse;
  assign bus.total       = r_total;
  assign bus.total_ovf   = r_total_ovf;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Directed bench for ripple_count_sampler: one 16-bit and one 4-bit accumulator instance
// driven by the same ripple counter stimulus.
module tb_ripple_count_sampler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] q   = 4'd5;
  logic       en  = 1'b1;
  logic       clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int nv0;

  always #5 clk = ~clk;

  ripple_count_sampler_if #(.ACC_W(16)) if16 ();
  ripple_count_sampler_if #(.ACC_W(4))  if4 ();

  assign {if16.Q3, if16.Q2, if16.Q1, if16.Q0} = q;
  assign {if4.Q3,  if4.Q2,  if4.Q1,  if4.Q0}  = q;
  assign if16.en      = en;
  assign if4.en       = en;
  assign if16.clr_acc = clr;
  assign if4.clr_acc  = clr;

  ripple_count_sampler #(.SYNC_STAGES(2), .STABLE_CYCLES(2), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .bus(if16)
  );

  ripple_count_sampler #(.SYNC_STAGES(2), .STABLE_CYCLES(2), .ACC_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(if4)
  );

  always @(negedge clk) if (if16.count_valid) nvalid++;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic settle(input logic [3:0] v);
    @(posedge clk); #1 q = v;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  // Leaves the bench just after the edge that should register count_valid
  task automatic step(input logic [3:0] v, input bit clr_at_accept, input string tag);
    @(posedge clk); #1 q = v;
    repeat (5) @(posedge clk);
    #1;
    chk({tag, "_early_cv"}, 32'(if16.count_valid), 0);
    if (clr_at_accept) clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk({tag, "_cv"}, 32'(if16.count_valid), 1);
  endtask

  task automatic pulse_end(input string tag);
    @(posedge clk); #1;
    chk({tag, "_cv_end"},   32'(if16.count_valid), 0);
    chk({tag, "_wrap_end"}, 32'(if16.wrap_pulse), 0);
  endtask

  initial begin
    // Reset with Q=5 held
    @(posedge clk); #1;
    chk("rst_count_sync", 32'(if16.count_sync), 0);
    chk("rst_cv",         32'(if16.count_valid), 0);
    chk("rst_delta",      32'(if16.delta), 0);
    chk("rst_wrap",       32'(if16.wrap_pulse), 0);
    chk("rst_total",      32'(if16.total), 0);
    chk("rst_ovf",        32'(if16.total_ovf), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("init_baseline",  32'(if16.count_sync), 5);
    chk("init_no_cv",     32'(nvalid), 0);
    chk("init_total",     32'(if16.total), 0);

    // Clean step 0 -> 3
    settle(4'd0);
    clr_pulse();
    chk("t2_cleared", 32'(if16.total), 0);
    step(4'd3, 1'b0, "t2");
    chk("t2_count",  32'(if16.count_sync), 3);
    chk("t2_delta",  32'(if16.delta), 3);
    chk("t2_wrap",   32'(if16.wrap_pulse), 0);
    chk("t2_total",  32'(if16.total), 3);
    pulse_end("t2");

    // Ripple 7 -> 6 -> 4 -> 0 -> 8
    settle(4'd7);
    chk("t3_base_total", 32'(if16.total), 7);
    nv0 = nvalid;
    @(posedge clk); #1 q = 4'd6;
    @(posedge clk); #1 q = 4'd4;
    @(posedge clk); #1 q = 4'd0;
    @(posedge clk); #1 q = 4'd8;
    repeat (12) @(posedge clk);
    #1;
    chk("t3_single_event", 32'(nvalid - nv0), 1);
    chk("t3_count",        32'(if16.count_sync), 8);
    chk("t3_delta",        32'(if16.delta), 1);
    chk("t3_total",        32'(if16.total), 8);

    // Wrap 14 -> 2
    settle(4'd14);
    step(4'd2, 1'b0, "t4");
    chk("t4_wrap",    32'(if16.wrap_pulse), 1);
    chk("t4_delta",   32'(if16.delta), 4);
    chk("t4_count",   32'(if16.count_sync), 2);
    chk("t4_total",   32'(if16.total), 18);
    chk("t4_total4",  32'(if4.total), 2);
    chk("t4_ovf4",    32'(if4.total_ovf), 1);
    chk("t4_ovf16",   32'(if16.total_ovf), 0);
    pulse_end("t4");
    chk("t4_delta_hold", 32'(if16.delta), 4);

    // Enable drop re-baselines
    settle(4'd3);
    nv0 = nvalid;
    @(posedge clk); #1 en = 1'b0; q = 4'd9;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_dis_count", 32'(if16.count_sync), 3);
    chk("t6_dis_no_cv", 32'(nvalid - nv0), 0);
    en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_rebase",    32'(if16.count_sync), 9);
    chk("t6_no_cv",     32'(nvalid - nv0), 0);
    chk("t6_total",     32'(if16.total), 19);
    step(4'd10, 1'b0, "t6");
    chk("t6_delta",     32'(if16.delta), 1);
    chk("t6_total2",    32'(if16.total), 20);

    // 4-bit accumulator overflow and clear-during-accept
    settle(4'd0);
    clr_pulse();
    step(4'd13, 1'b0, "t5a");
    chk("t5a_total4", 32'(if4.total), 13);
    chk("t5a_ovf4",   32'(if4.total_ovf), 0);
    step(4'd2, 1'b0, "t5b");
    chk("t5b_delta",  32'(if4.delta), 5);
    chk("t5b_total4", 32'(if4.total), 2);
    chk("t5b_ovf4",   32'(if4.total_ovf), 1);
    chk("t5b_total16", 32'(if16.total), 18);
    step(4'd3, 1'b0, "t5c");
    chk("t5c_total4", 32'(if4.total), 3);
    chk("t5c_ovf4",   32'(if4.total_ovf), 1);
    step(4'd5, 1'b1, "t5d");
    chk("t5d_cv4",    32'(if4.count_valid), 1);
    chk("t5d_delta4", 32'(if4.delta), 2);
    chk("t5d_total4", 32'(if4.total), 0);
    chk("t5d_ovf4",   32'(if4.total_ovf), 0);
    chk("t5d_total16", 32'(if16.total), 0);
    pulse_end("t5d");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ripple_count_sampler.md
Name: ripple_count_sampler

Overview:
- Downstream consumer of the 4-bit asynchronous ripple counter outputs Q0..Q3.
- Brings the ripple outputs into the clk domain and filters out ripple transients; only settled values are accepted.
- For each accepted change, emits the count, the increment since the last accepted value and a wrap flag, and updates a running event total.
- Provides a clean synchronous event count for downstream logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages per input bit in the synchronizer (min 2)
STABLE_CYCLES, 2, consecutive identical synchronized samples required before a value is accepted (min 1)
ACC_W, 16, width of the running total (min 4)

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
Q0  input  1  ripple counter bit 0, asynchronous to clk
Q1  input  1  ripple counter bit 1, asynchronous
Q2  input  1  ripple counter bit 2, asynchronous
Q3  input  1  ripple counter bit 3 (MSB), asynchronous
en  input  1  sampling enable; low suspends acceptance
clr_acc  input  1  synchronous clear of total and total_ovf
count_sync  output  4  last accepted counter value
count_valid  output  1  one-cycle pulse: new value accepted
delta  output  4  (new - previous accepted) mod 16; valid with count_valid
wrap_pulse  output  1  one-cycle pulse with count_valid when new < previous (unsigned)
total  output  ACC_W  running sum of deltas, wraps mod 2^ACC_W
total_ovf  output  1  sticky; set when total wraps

Behaviour:
- Reset (rst high at posedge):
  - Synchronizer flops, stability counter and all outputs go to 0.
  - State goes to S_INIT.
  - Reset has priority over every other input.
- Synchronizer:
  - Each Q bit passes through SYNC_STAGES flops independently, forming s[3:0] = {Q3,Q2,Q1,Q0}.
  - No gray coding; coherence comes from the stability filter.
- Stability filter:
  - s_prev registers s each cycle.
  - stab_cnt resets to 0 when s != s_prev.
  - Otherwise stab_cnt increments, saturating at STABLE_CYCLES.
  - A value is stable in the cycle where stab_cnt == STABLE_CYCLES.
- State S_INIT:
  - On the first stable value with en=1, load count_sync = s and go to S_TRACK.
  - No count_valid, delta, wrap_pulse or total change in this case.
- State S_TRACK, stable value with en=1 and s != count_sync:
  - Registered at the next edge: count_sync <= s, delta <= s - count_sync (4-bit modulo), count_valid <= 1.
  - wrap_pulse <= (s < count_sync).
  - total <= total + zero-extended delta.
  - total_ovf <= 1 if that addition carries out.
- State S_TRACK, stable value equal to count_sync: no event.
- Once a value has been accepted, stab_cnt holding at saturation does not re-trigger while s is unchanged.
- Pulses: count_valid and wrap_pulse are high for exactly one cycle per event; 0 otherwise. delta holds its last value.
- Latency: a clean input change, with all bits changed before the same edge, produces count_valid exactly SYNC_STAGES+STABLE_CYCLES+1 cycles after that edge (5 cycles at defaults).
- Ripple transients: intermediate values that persist for fewer than STABLE_CYCLES synchronized cycles are never accepted.
- en=0:
  - No acceptance.
  - State forced to S_INIT at the next edge, so a new baseline is captured after re-enable and counts accrued while disabled are discarded.
  - The synchronizer keeps running.
  - total and total_ovf are held.
- clr_acc=1:
  - total <= 0 and total_ovf <= 0, with priority over accumulation in the same cycle.
  - A delta accepted in that same cycle is dropped from total but is still reported on delta and count_valid.
- Aliasing limitation: an advance of 16 or more counts between acceptances is aliased mod 16. The upstream count rate must stay below one count per (SYNC_STAGES+STABLE_CYCLES) clk cycles.
- Reset mid-operation: any pending acceptance is discarded and a new baseline is captured after release.

Test Plan:
1. Hold Q=4'b0101, rst high for 2 cycles, then low, en=1 -> all outputs 0 during reset. After release, count_sync=5 loaded with no count_valid and total=0.
2. Baseline 0; step Q to 3 cleanly -> count_valid high for 1 cycle exactly 5 cycles later, with count_sync=3, delta=3, wrap_pulse=0, total=3.
3. Baseline 7; apply ripple sequence 6, 4, 0 (each held 1 clk), then 8 held -> a single count_valid with count_sync=8, delta=1. No event for 6, 4 or 0.
4. Baseline 14; step to 2 -> count_valid=1, wrap_pulse=1, delta=4, total += 4.
5. ACC_W=4, total=13; accept delta=5 -> total=2, total_ovf=1. Next accept delta=1 -> total=3, total_ovf stays 1. Assert clr_acc in the same cycle as an accept of delta=2 -> total=0, total_ovf=0, count_valid=1, delta=2.
6. Baseline 3; drop en, move Q to 9, raise en -> no count_valid and count_sync=9 (re-baselined). Then step Q to 10 -> count_valid with delta=1.
